// File: rtl/videoram_streamer.sv
// Read-side master for the 32-bit videoram port. Sweeps NUM_WORDS words from BASE_ADDR and
// prefetches them into a small word FIFO. Credits cover both buffered and in-flight reads, so a
// stalled consumer can never overrun the FIFO. Each word is emitted as four bytes, least
// significant byte first, with sof/eof framing and a registered done pulse.
module videoram_streamer #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned NUM_WORDS  = 4096,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [31:0]       vram_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned FcW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0]   LastWord = CntW'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] Base     = ADDR_W'(BASE_ADDR);
  localparam logic [FcW-1:0]    Depth    = FcW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [CntW-1:0]       issued_q;
  logic [CntW-1:0]       out_word_q;
  logic [RD_LATENCY-1:0] pipe_q;
  logic [31:0]           fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [FcW-1:0]        fifo_cnt_q;
  logic [1:0]            byte_q;
  logic                  done_q;

  logic [FcW-1:0] inflight;
  logic [31:0]    head;
  logic           go, issue, push, pop, xfer, last_xfer;

  // Count reads still travelling through the RAM latency pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      inflight = inflight + FcW'(pipe_q[i]);
    end
  end

  // Credit check, capture/pop strobes and the byte output view of the FIFO head.
  always_comb begin
    go        = (state_q == StIdle) && start;
    issue     = (state_q == StFetch) && ((fifo_cnt_q + inflight) < Depth);
    push      = pipe_q[RD_LATENCY-1];
    head      = fifo_mem[rd_ptr_q];
    out_valid = (fifo_cnt_q != '0);
    out_data  = out_valid ? head[8*byte_q +: 8] : 8'h00;
    out_sof   = out_valid && (out_word_q == '0) && (byte_q == 2'd0);
    out_eof   = out_valid && (out_word_q == LastWord) && (byte_q == 2'd3);
    xfer      = out_valid && out_ready;
    pop       = xfer && (byte_q == 2'd3);
    last_xfer = xfer && out_eof;
  end

  // Next-state logic: fetch until every read is issued, then drain until eof is accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: if (issue && (issued_q == LastWord)) state_d = StDrain;
      StDrain: if (last_xfer) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state, address/issue counters, latency pipe, FIFO pointers and byte framing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= Base;
      issued_q   <= '0;
      out_word_q <= '0;
      pipe_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      byte_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_xfer;
      pipe_q[0] <= issue;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      if (go) begin
        addr_q   <= Base;
        issued_q <= '0;
      end else if (issue) begin
        addr_q   <= addr_q + 1'b1;
        issued_q <= issued_q + 1'b1;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + 1'b1;
      end else if (pop && !push) begin
        fifo_cnt_q <= fifo_cnt_q - 1'b1;
      end
      if (xfer) begin
        byte_q <= byte_q + 1'b1;
        if (byte_q == 2'd3) out_word_q <= last_xfer ? '0 : out_word_q + 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= vram_data;
  end

  // The credit rule must make a write into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && (fifo_cnt_q == Depth)));
  end

  assign vram_addr = addr_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

endmodule

// File: tb/tb_videoram_streamer.sv
// Bench for videoram_streamer: three instances cover the basic sweep with a cycle table,
// long read latency with address wrap under random backpressure, and a one-word sweep.
module tb_videoram_streamer;

  logic clk = 1'b0;
  logic reset, start, ready;
  int   sel;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Instance A: base 0x010, 2 words, latency 1
  logic        busy_a, done_a, ov_a, sof_a, eof_a;
  logic [11:0] addr_a;
  logic [31:0] vd_a;
  logic [7:0]  od_a;
  // Instance B: base 0xFFE, 4 words (wraps), latency 3
  logic        busy_b, done_b, ov_b, sof_b, eof_b;
  logic [11:0] addr_b;
  logic [31:0] vd_b;
  logic [7:0]  od_b;
  // Instance C: base 0x020, 1 word, latency 2
  logic        busy_c, done_c, ov_c, sof_c, eof_c;
  logic [11:0] addr_c;
  logic [31:0] vd_c;
  logic [7:0]  od_c;

  logic        m_busy, m_done, m_valid, m_sof, m_eof;
  logic [11:0] m_addr;
  logic [7:0]  m_data;

  videoram_streamer #(.ADDR_W(12), .BASE_ADDR(12'h010), .NUM_WORDS(2), .RD_LATENCY(1),
                      .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .start(start && sel == 0), .busy(busy_a), .done(done_a),
    .vram_addr(addr_a), .vram_data(vd_a), .out_data(od_a), .out_valid(ov_a),
    .out_ready(ready && sel == 0), .out_sof(sof_a), .out_eof(eof_a)
  );

  videoram_streamer #(.ADDR_W(12), .BASE_ADDR(12'hFFE), .NUM_WORDS(4), .RD_LATENCY(3),
                      .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .start(start && sel == 1), .busy(busy_b), .done(done_b),
    .vram_addr(addr_b), .vram_data(vd_b), .out_data(od_b), .out_valid(ov_b),
    .out_ready(ready && sel == 1), .out_sof(sof_b), .out_eof(eof_b)
  );

  videoram_streamer #(.ADDR_W(12), .BASE_ADDR(12'h020), .NUM_WORDS(1), .RD_LATENCY(2),
                      .FIFO_DEPTH(4)) u_c (
    .clk(clk), .reset(reset), .start(start && sel == 2), .busy(busy_c), .done(done_c),
    .vram_addr(addr_c), .vram_data(vd_c), .out_data(od_c), .out_valid(ov_c),
    .out_ready(ready && sel == 2), .out_sof(sof_c), .out_eof(eof_c)
  );

  function automatic logic [31:0] pat(input logic [11:0] a);
    return 32'(a) * 32'h01010101 + 32'h03020100;
  endfunction

  // RAM models: registered reads delayed to each instance's latency
  logic [31:0] rb0, rb1, rc0;
  always @(posedge clk) begin
    vd_a <= pat(addr_a);
    rb0  <= pat(addr_b);
    rb1  <= rb0;
    vd_b <= rb1;
    rc0  <= 32'hDDCCBBAA;
    vd_c <= rc0;
  end

  always_comb begin
    case (sel)
      1: {m_busy, m_done, m_valid, m_sof, m_eof, m_addr, m_data} =
           {busy_b, done_b, ov_b, sof_b, eof_b, addr_b, od_b};
      2: {m_busy, m_done, m_valid, m_sof, m_eof, m_addr, m_data} =
           {busy_c, done_c, ov_c, sof_c, eof_c, addr_c, od_c};
      default: {m_busy, m_done, m_valid, m_sof, m_eof, m_addr, m_data} =
           {busy_a, done_a, ov_a, sof_a, eof_a, addr_a, od_a};
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int s, input logic [11:0] base, input int k);
    logic [31:0] w;
    logic [11:0] a;
    a = base + 12'(k / 4);
    w = (s == 2) ? 32'hDDCCBBAA : pat(a);
    return w[8*(k%4) +: 8];
  endfunction

  // Runs one full sweep on the selected instance, checking every accepted byte.
  task automatic run_stream(input int s, input int num, input int pct, input logic [11:0] base);
    int k;
    int dones;
    int cyc;
    bit stalled;
    logic [7:0] held;
    k = 0; dones = 0; cyc = 0; stalled = 0; held = '0;
    sel = s;
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (dones == 0 && cyc < 3000) begin
      ready = ($urandom_range(0, 99) < pct);
      if (m_valid) begin
        if (stalled) check($sformatf("stall_hold s%0d k%0d", s, k), 32'(m_data), 32'(held));
        if (ready) begin
          check($sformatf("byte s%0d k%0d", s, k), {m_sof, m_eof, m_data},
                {k == 0, k == 4 * num - 1, exp_byte(s, base, k)});
          k++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = m_data;
        end
      end
      if (m_done) begin
        dones++;
        check($sformatf("busy_at_done s%0d", s), 32'(m_busy), 32'd0);
      end
      tick();
      cyc++;
    end
    ready = 1'b0;
    check($sformatf("byte_count s%0d", s), k, 4 * num);
    check($sformatf("done_seen s%0d", s), dones, 1);
    check($sformatf("idle_after s%0d", s), {m_busy, m_done, m_valid}, 32'd0);
  endtask

  typedef struct {
    logic       start;
    logic       ready;
    logic       valid;
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       busy;
    logic       done;
    logic [11:0] addr;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // Instance A cycle table: words 0x13121110 @0x010 and 0x14131211 @0x011
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h010};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 12'h010};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 12'h011};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 12'h012};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 12'h012};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 12'h012};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 12'h012};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0, 12'h012};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 12'h012};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 12'h012};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0, 12'h012};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 1'b0, 12'h012};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 1'b0, 12'h012};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 12'h012};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h012};

    reset = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    sel   = 0;
    tick();
    tick();
    reset = 1'b0;

    check("reset_a", {busy_a, done_a, ov_a, sof_a, eof_a, od_a, addr_a},
          {5'b0, 8'h00, 12'h010});
    check("reset_b", {busy_b, done_b, ov_b, addr_b}, {4'b0, 12'hFFE});
    check("reset_c", {busy_c, done_c, ov_c, addr_c}, {4'b0, 12'h020});

    // Cycle-exact sweep with stalls and an ignored mid-sweep start
    for (int i = 0; i < 15; i++) begin
      start = tbl[i].start;
      ready = tbl[i].ready;
      check($sformatf("table row %0d", i),
            {m_valid, m_data, m_sof, m_eof, m_busy, m_done, m_addr},
            {tbl[i].valid, tbl[i].data, tbl[i].sof, tbl[i].eof, tbl[i].busy, tbl[i].done,
             tbl[i].addr});
      tick();
    end
    start = 1'b0;

    // Reset in the middle of FETCH with the consumer stalled
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("fetch_busy", {m_busy, m_addr}, {1'b1, 12'h011});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid", {m_busy, m_done, m_valid, m_sof, m_eof, m_data, m_addr},
          {5'b0, 8'h00, 12'h010});
    run_stream(0, 2, 100, 12'h010);

    // Wrapping address range: full-rate, then 30% backpressure
    run_stream(1, 4, 100, 12'hFFE);
    run_stream(1, 4, 30, 12'hFFE);

    // Single-word sweep: AA(sof) BB CC DD(eof)
    run_stream(2, 1, 100, 12'h020);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
